// File: rtl/vec_mem_pkg.sv
// Shared types and sizing for the vector memory sequencer.
package vec_mem_pkg;

  localparam int LANES  = 8;
  localparam int WORD_W = 32;
  localparam int VEC_W  = LANES * WORD_W;
  localparam int BEAT_W = $clog2(LANES);

  // Sequencer states: pass-through/accept, load beats, store beats, handoff.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } seqState_t;

endpackage

// File: rtl/vec_lane_buf.sv
// Lane-organised vector register: per-lane write, parallel load, lane-select read.
module vec_lane_buf #(
  parameter int NLANES = vec_mem_pkg::LANES,
  parameter int LW     = vec_mem_pkg::WORD_W,
  parameter int SW     = $clog2(NLANES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 loadAll,
  input  logic [NLANES*LW-1:0] loadData,
  input  logic                 laneWe,
  input  logic [SW-1:0]        laneSel,
  input  logic [LW-1:0]        laneData,
  input  logic [SW-1:0]        rdSel,
  output logic [LW-1:0]        rdData,
  output logic [NLANES*LW-1:0] allData
);

  logic [LW-1:0] lanesReg [NLANES];

  genvar gi;
  generate
    for (gi = 0; gi < NLANES; gi++) begin : g_lane
      // Each lane clears, bulk-loads, or takes a single-lane write when selected.
      always_ff @(posedge clk) begin
        if (reset || clear) begin
          lanesReg[gi] <= '0;
        end else if (loadAll) begin
          lanesReg[gi] <= loadData[gi*LW +: LW];
        end else if (laneWe && (laneSel == SW'(gi))) begin
          lanesReg[gi] <= laneData;
        end
      end

      assign allData[gi*LW +: LW] = lanesReg[gi];
    end
  endgenerate

  assign rdData = lanesReg[rdSel];

endmodule

// File: rtl/vec_mem_sequencer.sv
// Serialises vector loads/stores onto the 32-bit data port; scalars pass through.
module vec_mem_sequencer #(
  parameter int LANES  = vec_mem_pkg::LANES,
  parameter int WORD_W = vec_mem_pkg::WORD_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      memwriteM,
  input  logic                      memreadM,
  input  logic                      VmemwriteM,
  input  logic                      VmemreadM,
  input  logic [31:0]               aluoutM,
  input  logic [31:0]               writedataM,
  input  logic [LANES*WORD_W-1:0]   VwritedataM,
  output logic [31:0]               readdataM,
  output logic [LANES*WORD_W-1:0]   VreaddataM,
  output logic                      stallM,
  output logic                      seq_err,
  output logic [31:0]               mem_addr,
  output logic                      mem_we,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata
);

  import vec_mem_pkg::*;

  localparam int SEL_W = $clog2(LANES);
  localparam int VW    = LANES * WORD_W;

  seqState_t        stateReg, stateNext;
  logic [SEL_W-1:0] beatReg, beatNext;
  logic [31:0]      baseReg, baseNext;

  logic             vecReq;
  logic             scalarReq;
  logic             lastBeat;
  logic             acceptStore;
  logic [31:0]      beatOffset;
  logic [WORD_W-1:0] storeLane;
  logic [WORD_W-1:0] unusedLoadLane;
  logic [VW-1:0]     unusedStoreVec;

  assign vecReq      = VmemreadM | VmemwriteM;
  assign scalarReq   = memreadM | memwriteM;
  assign lastBeat    = (beatReg == SEL_W'(LANES - 1));
  // A simultaneous vector load and store is treated as a load.
  assign acceptStore = (stateReg == IDLE) && VmemwriteM && !VmemreadM;
  assign beatOffset  = {{(30 - SEL_W){1'b0}}, beatReg, 2'b00};
  assign readdataM   = mem_rdata;

  // Assembles incoming load words; holds the last loaded vector until overwritten.
  vec_lane_buf #(.NLANES(LANES), .LW(WORD_W), .SW(SEL_W)) loadBuf (
    .clk      (clk),
    .reset    (reset),
    .clear    (1'b0),
    .loadAll  (1'b0),
    .loadData ('0),
    .laneWe   (stateReg == LOAD),
    .laneSel  (beatReg),
    .laneData (mem_rdata),
    .rdSel    (beatReg),
    .rdData   (unusedLoadLane),
    .allData  (VreaddataM)
  );

  // Captures store data at accept so the datapath is free to change during beats.
  vec_lane_buf #(.NLANES(LANES), .LW(WORD_W), .SW(SEL_W)) storeBuf (
    .clk      (clk),
    .reset    (reset),
    .clear    (1'b0),
    .loadAll  (acceptStore),
    .loadData (VwritedataM),
    .laneWe   (1'b0),
    .laneSel  (beatReg),
    .laneData ('0),
    .rdSel    (beatReg),
    .rdData   (storeLane),
    .allData  (unusedStoreVec)
  );

  // State, beat counter and latched base address.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
      beatReg  <= '0;
      baseReg  <= '0;
    end else begin
      stateReg <= stateNext;
      beatReg  <= beatNext;
      baseReg  <= baseNext;
    end
  end

  // Next-state and memory-port steering; reset forces a quiet pass-through.
  always_comb begin
    stateNext = stateReg;
    beatNext  = beatReg;
    baseNext  = baseReg;
    mem_addr  = aluoutM;
    mem_we    = 1'b0;
    mem_wdata = writedataM;
    stallM    = 1'b0;
    seq_err   = 1'b0;

    case (stateReg)
      IDLE: begin
        if (vecReq) begin
          stallM    = 1'b1;
          seq_err   = scalarReq;
          baseNext  = {aluoutM[31:2], 2'b00};
          beatNext  = '0;
          stateNext = VmemreadM ? LOAD : STORE;
        end else begin
          mem_we = memwriteM;
        end
      end
      LOAD, STORE: begin
        stallM   = 1'b1;
        mem_addr = baseReg + beatOffset;
        beatNext = beatReg + 1'b1;
        if (stateReg == STORE) begin
          mem_we    = 1'b1;
          mem_wdata = storeLane;
        end
        if (lastBeat) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    // No memory write may escape in a reset cycle, even mid-transfer.
    if (reset) begin
      mem_addr  = aluoutM;
      mem_wdata = writedataM;
      mem_we    = 1'b0;
      stallM    = 1'b0;
      seq_err   = 1'b0;
    end
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer with a behavioural 256-word data memory.
module tb_vec_mem_sequencer;

  localparam int LANES  = 8;
  localparam int WORD_W = 32;
  localparam int VW     = LANES * WORD_W;

  localparam logic [31:0] WRAP_ADDR [8] = '{
    32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000,
    32'h0000_0004, 32'h0000_0008, 32'h0000_000C, 32'h0000_0010
  };
  localparam logic [31:0] WRAP_DATA [8] = '{
    32'hA000_00FD, 32'hA000_00FE, 32'hA000_00FF, 32'hA000_0000,
    32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004
  };

  logic          clk;
  logic          reset;
  logic          memwriteM, memreadM, VmemwriteM, VmemreadM;
  logic [31:0]   aluoutM, writedataM;
  logic [VW-1:0] VwritedataM;
  logic [31:0]   readdataM;
  logic [VW-1:0] VreaddataM;
  logic          stallM, seq_err;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic          mem_we;

  logic          memInit;
  logic [31:0]   mem [256];

  int            vecCount  = 0;
  int            missCount = 0;

  logic [31:0]   addrLog [8];
  logic [31:0]   wdLog [8];
  int            stallCnt, weCnt, errCnt;
  logic [VW-1:0] doneVec;
  logic          doneStall;
  logic [VW-1:0] storeVec, rstVec, expVec;

  vec_mem_sequencer #(.LANES(LANES), .WORD_W(WORD_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .memwriteM   (memwriteM),
    .memreadM    (memreadM),
    .VmemwriteM  (VmemwriteM),
    .VmemreadM   (VmemreadM),
    .aluoutM     (aluoutM),
    .writedataM  (writedataM),
    .VwritedataM (VwritedataM),
    .readdataM   (readdataM),
    .VreaddataM  (VreaddataM),
    .stallM      (stallM),
    .seq_err     (seq_err),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on the rising edge, known fill pattern.
  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[9:2]];

  task automatic checkVal(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one vector request from accept through DONE (10 cycles), logging the port.
  task automatic runVec(input bit isStore, input logic [31:0] base, input logic [VW-1:0] wdata,
                        input bit keep);
    VmemwriteM  = isStore;
    VmemreadM   = !isStore;
    aluoutM     = base;
    VwritedataM = wdata;
    stallCnt = 0; weCnt = 0; errCnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (stallM)  stallCnt++;
      if (seq_err) errCnt++;
      if (mem_we)  weCnt++;
      if (c >= 1 && c <= 8) begin
        addrLog[c-1] = mem_addr;
        wdLog[c-1]   = mem_wdata;
      end
      if (c == 9) begin
        doneVec   = VreaddataM;
        doneStall = stallM;
        if (!keep) begin
          VmemwriteM = 1'b0;
          VmemreadM  = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    $display("vec %s base=%08h stall=%0d we=%0d err=%0d vec=%0h",
             isStore ? "store" : "load ", base, stallCnt, weCnt, errCnt, doneVec);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; memInit = 1'b1;
    memwriteM = 1'b0; memreadM = 1'b0; VmemwriteM = 1'b0; VmemreadM = 1'b0;
    aluoutM = 32'h24; writedataM = 32'h0; VwritedataM = '0;
    for (int k = 0; k < LANES; k++) begin
      storeVec[k*32 +: 32] = 32'h1111_1111 * 32'(k);
      rstVec[k*32 +: 32]   = 32'h5500_0000 + 32'(k);
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkVal("rst_stall", VW'(stallM), VW'(0));
    checkVal("rst_err", VW'(seq_err), VW'(0));
    checkVal("rst_we", VW'(mem_we), VW'(0));
    checkVal("rst_vread", VreaddataM, VW'(0));
    checkVal("rst_addr", VW'(mem_addr), VW'(32'h24));
    $display("reset checked");
    @(posedge clk); #1;
    reset = 1'b0; memInit = 1'b0;

    // Scalar store then load
    memwriteM = 1'b1; aluoutM = 32'h40; writedataM = 32'hDEAD_BEEF;
    @(negedge clk);
    checkVal("sst_we", VW'(mem_we), VW'(1));
    checkVal("sst_addr", VW'(mem_addr), VW'(32'h40));
    checkVal("sst_stall", VW'(stallM), VW'(0));
    $display("scalar store addr=%08h data=%08h", mem_addr, mem_wdata);
    @(posedge clk); #1;
    memwriteM = 1'b0; memreadM = 1'b1;
    @(negedge clk);
    checkVal("sld_data", VW'(readdataM), VW'(32'hDEAD_BEEF));
    checkVal("sld_stall", VW'(stallM), VW'(0));
    $display("scalar load addr=%08h data=%08h", mem_addr, readdataM);
    @(posedge clk); #1;
    memreadM = 1'b0;

    // Vector store at 0x100
    runVec(1'b1, 32'h100, storeVec, 1'b0);
    checkVal("vst_stall", VW'(stallCnt), VW'(9));
    checkVal("vst_we", VW'(weCnt), VW'(8));
    checkVal("vst_done_stall", VW'(doneStall), VW'(0));
    for (int k = 0; k < LANES; k++) begin
      checkVal($sformatf("vst_addr%0d", k), VW'(addrLog[k]), VW'(32'h100 + 32'(4*k)));
      checkVal($sformatf("vst_wdata%0d", k), VW'(wdLog[k]), VW'(32'h1111_1111 * 32'(k)));
      checkVal($sformatf("vst_mem%0d", k), VW'(mem[8'h40 + 8'(k)]), VW'(32'h1111_1111 * 32'(k)));
    end

    // Vector load back, then a back-to-back reload
    runVec(1'b0, 32'h100, '0, 1'b1);
    checkVal("vld_vec", doneVec, storeVec);
    checkVal("vld_done_stall", VW'(doneStall), VW'(0));
    checkVal("vld_stall", VW'(stallCnt), VW'(9));
    checkVal("vld_we", VW'(weCnt), VW'(0));
    runVec(1'b0, 32'h100, '0, 1'b0);
    checkVal("b2b_stall", VW'(stallCnt), VW'(9));
    checkVal("b2b_vec", doneVec, storeVec);

    // Address wrap past the top of the address space
    runVec(1'b0, 32'hFFFF_FFF4, '0, 1'b0);
    for (int k = 0; k < LANES; k++) begin
      checkVal($sformatf("wrap_addr%0d", k), VW'(addrLog[k]), VW'(WRAP_ADDR[k]));
      expVec[k*32 +: 32] = WRAP_DATA[k];
    end
    checkVal("wrap_vec", doneVec, expVec);

    // Unaligned base is word-aligned
    runVec(1'b0, 32'h103, '0, 1'b0);
    checkVal("align_addr0", VW'(addrLog[0]), VW'(32'h100));
    checkVal("align_addr7", VW'(addrLog[7]), VW'(32'h11C));
    checkVal("align_vec", doneVec, storeVec);

    // Scalar store collides with vector load
    memwriteM = 1'b1; writedataM = 32'h0000_0BAD;
    runVec(1'b0, 32'h200, '0, 1'b0);
    memwriteM = 1'b0;
    for (int k = 0; k < LANES; k++) expVec[k*32 +: 32] = 32'hA000_0080 + 32'(k);
    checkVal("coll_err", VW'(errCnt), VW'(1));
    checkVal("coll_we", VW'(weCnt), VW'(0));
    checkVal("coll_stall", VW'(stallCnt), VW'(9));
    checkVal("coll_vec", doneVec, expVec);
    checkVal("coll_mem", VW'(mem[8'h80]), VW'(32'hA000_0080));

    // Reset during beat 3 of a store to 0x300
    VmemwriteM = 1'b1; aluoutM = 32'h300; VwritedataM = rstVec;
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1; VmemwriteM = 1'b0;
    @(negedge clk);
    checkVal("mid_rst_we", VW'(mem_we), VW'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkVal("post_rst_stall", VW'(stallM), VW'(0));
    checkVal("post_rst_we", VW'(mem_we), VW'(0));
    checkVal("post_rst_vread", VreaddataM, VW'(0));
    checkVal("post_rst_addr", VW'(mem_addr), VW'(32'h300));
    for (int k = 0; k < LANES; k++) begin
      checkVal($sformatf("rst_mem%0d", k), VW'(mem[8'hC0 + 8'(k)]),
               (k < 3) ? VW'(32'h5500_0000 + 32'(k)) : VW'(32'hA000_00C0 + 32'(k)));
    end
    $display("reset mid-store checked");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
